// File: rtl/core_ctrl_fsm.sv
// core_ctrl_fsm: multi-cycle main control FSM for the RV32I core.
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and drives the imem/dmem
// handshakes plus every datapath enable. It traps on illegal opcodes and on
// memory timeouts.
// Optional build macro CORE_CTRL_PERF_EN adds the cycle_count/instret_count
// performance counters and their ports.
`timescale 1ns/1ps

`ifndef INSTR_SIZE
`define INSTR_SIZE 32
`endif

module core_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [`INSTR_SIZE-1:0] instr,
  output logic                   imem_req,
  input  logic                   imem_ack,
  output logic                   dmem_req,
  output logic                   dmem_we,
  input  logic                   dmem_ack,
  input  logic                   branch_taken,
  output logic                   ir_we,
  output logic                   pc_we,
  output logic [1:0]             pc_sel,
  output logic                   reg_write,
  output logic [1:0]             wb_sel,
  output logic                   alu_src_imm,
  output logic [1:0]             alu_op,
  output logic                   trap,
  output logic [1:0]             trap_cause,
  output logic                   busy
`ifdef CORE_CTRL_PERF_EN
  ,
  output logic [31:0]            cycle_count,
  output logic [31:0]            instret_count
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_TARGET = 2'd1;
  localparam logic [1:0] PC_JALR   = 2'd2;
  localparam logic [1:0] PC_TRAP   = 2'd3;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_FUNCT = 2'd1;
  localparam logic [1:0] ALU_CMP   = 2'd2;
  localparam logic [1:0] ALU_PASS  = 2'd3;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_IMEM_TO = 2'd2;
  localparam logic [1:0] CAUSE_DMEM_TO = 2'd3;

  logic [2:0]      state;
  logic [2:0]      next_state;
  logic [1:0]      cause_q;
  logic [1:0]      next_cause;
  logic [TO_W-1:0] to_cnt;
  logic [6:0]      opcode;
  logic            is_store;
  logic            is_jump;
  logic            legal_opcode;
  logic            wait_state;
  logic            ack_now;
  logic            timed_out;
  logic            unused_instr_bits;

  // The IR is held by the datapath, so the opcode stays valid from DECODE to WB.
  assign opcode            = instr[6:0];
  assign unused_instr_bits = ^instr[`INSTR_SIZE-1:7];
  assign is_store          = (opcode == OPC_STORE);
  assign is_jump           = (opcode == OPC_JAL) || (opcode == OPC_JALR);

  // Decode the legal RV32I base opcode set.
  always_comb begin
    legal_opcode = 1'b0;
    case (opcode)
      OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
      OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: legal_opcode = 1'b1;
      default:                               legal_opcode = 1'b0;
    endcase
  end

  // Timeout detection. An ack in the final allowed cycle beats the timeout.
  always_comb begin
    wait_state = (state == S_FETCH) || (state == S_MEM);
    ack_now    = (state == S_FETCH) ? imem_ack : dmem_ack;
    timed_out  = (MEM_TIMEOUT != 0) && wait_state && !ack_now &&
                 (int'(to_cnt) == MEM_TIMEOUT - 1);
  end

  // Next-state and trap-cause selection.
  always_comb begin
    next_state = state;
    next_cause = cause_q;
    case (state)
      S_IDLE:   next_state = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          next_state = S_DECODE;
        end else if (timed_out) begin
          next_state = S_TRAP;
          next_cause = CAUSE_IMEM_TO;
        end
      end
      S_DECODE: begin
        if (legal_opcode) begin
          next_state = S_EXEC;
        end else begin
          next_state = S_TRAP;
          next_cause = CAUSE_ILLEGAL;
        end
      end
      S_EXEC: begin
        case (opcode)
          OPC_LOAD, OPC_STORE: next_state = S_MEM;
          OPC_BRANCH:          next_state = S_FETCH;
          default:             next_state = S_WB;
        endcase
      end
      S_MEM: begin
        if (dmem_ack) begin
          next_state = is_store ? S_FETCH : S_WB;
        end else if (timed_out) begin
          next_state = S_TRAP;
          next_cause = CAUSE_DMEM_TO;
        end
      end
      S_WB:     next_state = S_FETCH;
      S_TRAP:   next_state = S_FETCH;
      default:  next_state = S_IDLE;
    endcase
  end

  // State, trap cause and timeout counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cause_q <= 2'd0;
      to_cnt  <= '0;
    end else begin
      state   <= next_state;
      cause_q <= next_cause;
      if ((next_state != state) || ack_now || !wait_state) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + TO_W'(1);
      end
    end
  end

  // Datapath control outputs, decoded from state, opcode and handshakes.
  always_comb begin
    imem_req    = 1'b0;
    ir_we       = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = PC_PLUS4;
    reg_write   = 1'b0;
    wb_sel      = WB_ALU;
    alu_src_imm = 1'b0;
    alu_op      = ALU_ADD;
    trap        = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ack;
      end
      S_EXEC: begin
        case (opcode)
          OPC_OP:    alu_op = ALU_FUNCT;
          OPC_OPIMM: begin
            alu_op      = ALU_FUNCT;
            alu_src_imm = 1'b1;
          end
          OPC_LOAD, OPC_STORE: begin
            alu_op      = ALU_ADD;
            alu_src_imm = 1'b1;
          end
          OPC_BRANCH: begin
            alu_op = ALU_CMP;
            pc_we  = 1'b1;
            pc_sel = branch_taken ? PC_TARGET : PC_PLUS4;
          end
          OPC_JAL: begin
            pc_we  = 1'b1;
            pc_sel = PC_TARGET;
          end
          OPC_JALR: begin
            pc_we  = 1'b1;
            pc_sel = PC_JALR;
          end
          OPC_LUI:   alu_op = ALU_PASS;
          default:   alu_op = ALU_ADD;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        pc_we    = is_store && dmem_ack;
      end
      S_WB: begin
        reg_write = 1'b1;
        if (opcode == OPC_LOAD) begin
          wb_sel = WB_LOAD;
        end else if (is_jump) begin
          wb_sel = WB_PC4;
        end
        pc_we = !is_jump;
      end
      S_TRAP: begin
        trap   = 1'b1;
        pc_we  = 1'b1;
        pc_sel = PC_TRAP;
      end
      default: ;
    endcase
  end

  assign trap_cause = cause_q;
  assign busy       = (state != S_IDLE);

`ifdef CORE_CTRL_PERF_EN
  logic retire;

  // An instruction retires on its final transition back into FETCH.
  assign retire = (state == S_WB) ||
                  ((state == S_MEM) && is_store && dmem_ack) ||
                  ((state == S_EXEC) && (opcode == OPC_BRANCH));

  // Busy-cycle and retired-instruction counters, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_count   <= 32'd0;
      instret_count <= 32'd0;
    end else begin
      if (busy) begin
        cycle_count <= cycle_count + 32'd1;
      end
      if (retire) begin
        instret_count <= instret_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/core_ctrl_fsm.md
Name: core_ctrl_fsm

Overview:
- Multi-cycle main control FSM for the RV32I core.
- Sequences fetch, decode, execute, memory and writeback for the decode/regfile/ALU datapath.
- Drives the instruction-memory and data-memory request/grant handshakes, plus all datapath enables: PC write, IR load, regfile write, ALU operand/op select, writeback mux.
- Traps on illegal opcodes and memory timeouts.

Parameters:
MEM_TIMEOUT, 255, max cycles waiting for imem/dmem ack before trap; 0 disables timeout
TO_W, 8, width of timeout counter; must hold MEM_TIMEOUT

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-high reset
instr  input  `INSTR_SIZE  IR contents (registered by datapath on ir_we)
imem_req  output  1  instruction fetch request
imem_ack  input  1  fetch data valid this cycle
dmem_req  output  1  data memory request
dmem_we  output  1  1=store, 0=load (valid with dmem_req)
dmem_ack  input  1  data access complete this cycle
branch_taken  input  1  ALU compare result, valid in EXEC
ir_we  output  1  load IR from imem data
pc_we  output  1  update PC
pc_sel  output  2  0=PC+4, 1=branch/JAL target, 2=JALR target, 3=trap vector
reg_write  output  1  regfile write enable
wb_sel  output  2  0=ALU, 1=load data, 2=PC+4
alu_src_imm  output  1  ALU operand B = imm_ext
alu_op  output  2  0=add, 1=funct-decoded (alu_funct), 2=branch compare, 3=pass-imm (LUI)
trap  output  1  one-cycle pulse on entering TRAP
trap_cause  output  2  1=illegal opcode, 2=imem timeout, 3=dmem timeout
busy  output  1  high in every state except IDLE

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Reset (sync, rst=1 at posedge):
  - state=IDLE, timeout counter=0.
  - All outputs 0, including pc_sel, wb_sel, alu_op, trap_cause.
  - rst mid-operation abandons any outstanding request; imem_req/dmem_req drop the next cycle.
- IDLE: go to FETCH the cycle after reset releases.
- FETCH:
  - imem_req=1 held until imem_ack.
  - On imem_ack: ir_we=1 same cycle, go to DECODE.
  - Counter increments each cycle without ack; reaching MEM_TIMEOUT -> TRAP, cause 2.
- DECODE: one cycle; opcode=instr[6:0].
  - Legal set: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111 -> EXEC.
  - Anything else -> TRAP, cause 1.
- EXEC (one cycle), per opcode:
  - OP: alu_op=1, alu_src_imm=0.
  - OP-IMM: alu_op=1, alu_src_imm=1.
  - LOAD/STORE: alu_op=0, alu_src_imm=1 (address calc) -> MEM.
  - BRANCH: alu_op=2; pc_we=1; pc_sel=1 if branch_taken else 0 -> FETCH.
  - JAL: pc_sel=1, pc_we=1 -> WB.
  - JALR: pc_sel=2, pc_we=1 -> WB.
  - LUI: alu_op=3 -> WB.
  - AUIPC: alu_op=0 -> WB.
  - All other opcodes -> WB.
- MEM:
  - dmem_req=1, dmem_we=1 for STORE, held until dmem_ack.
  - STORE ack: pc_we=1, pc_sel=0 -> FETCH.
  - LOAD ack -> WB.
  - Timeout -> TRAP, cause 3.
- WB:
  - reg_write=1 for one cycle.
  - wb_sel: 1 for LOAD, 2 for JAL/JALR, else 0.
  - Non-jump instructions: pc_we=1, pc_sel=0.
  - -> FETCH.
- TRAP:
  - trap=1 and pc_we=1, pc_sel=3 for one cycle.
  - trap_cause held until the next trap or reset -> FETCH.
- Timeout counter clears on every state change and on ack.
  - Ack in the same cycle the counter reaches MEM_TIMEOUT: ack wins.
- Register-writes-to-x0 suppression is done in the regfile, not here.
- Latency per instruction:
  - ALU/LUI/AUIPC/JAL/JALR: 4 + imem wait cycles.
  - Branch: 3 + imem wait cycles.
  - Store: 4 + imem wait + dmem wait cycles.
  - Load: 5 + imem wait + dmem wait cycles.
- All outputs are combinational from state, opcode and handshake inputs; no output depends on an input in a later cycle.

Optional Feature:
CORE_CTRL_PERF_EN:
- Adds outputs cycle_count [31:0] (increments every cycle busy=1) and instret_count [31:0] (increments on each transition into FETCH from WB, from MEM after a STORE, or from EXEC after a BRANCH).
- Both counters clear on rst and wrap modulo 2^32.
- Without the macro: no ports, no counters; the behaviour is otherwise identical.

Test Plan:
- ADD (instr 0x002081B3), imem_ack after 1 cycle -> FETCH, DECODE, EXEC with alu_op=1, alu_src_imm=0, then WB with reg_write=1, wb_sel=0, pc_we=1, pc_sel=0; 5 cycles from imem_req rise to next imem_req.
- LW (0x0000A103), dmem_ack delayed 3 cycles -> dmem_req=1, dmem_we=0 held 4 cycles, then WB with wb_sel=1; SW (0x0020A023) -> dmem_we=1, no reg_write, pc_we on ack.
- BEQ (0x00208463) with branch_taken=1 -> EXEC pc_we=1, pc_sel=1, no WB state; with branch_taken=0 -> pc_sel=0.
- Opcode 0x7F -> DECODE then TRAP; trap=1 for one cycle, trap_cause=1, pc_sel=3; next state FETCH.
- imem_ack never asserted, MEM_TIMEOUT=4 -> trap after 4 FETCH cycles with cause 2; ack on exactly the 4th cycle -> no trap.
- rst asserted during MEM wait -> next cycle dmem_req=0, state IDLE, all outputs 0; with CORE_CTRL_PERF_EN, instret_count=0 after reset and 3 after three ADDs.
